// File: rtl/sram_responder.sv
// Responder model of a 256Kx16 asynchronous SRAM: word storage, CE/OE/WE/UB/LB
// decode, emulated read latency and a tri-stated data bus with activity counters.
module sram_responder #(
    parameter int MEM_ADDR_W = 16,
    parameter int READ_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [15:0] SRAM_DQ,
    input  logic [17:0] SRAM_ADDR,
    input  logic        SRAM_UB_N,
    input  logic        SRAM_LB_N,
    input  logic        SRAM_WE_N,
    input  logic        SRAM_CE_N,
    input  logic        SRAM_OE_N,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic        busy,
    output logic        proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    localparam int       DEPTH      = 2 ** MEM_ADDR_W;
    localparam logic     LAT_OK     = (READ_LAT >= 1) && (READ_LAT <= 15);
    localparam logic     LAT_ONE    = (READ_LAT == 1);
    localparam logic [3:0] LAT_RELOAD = 4'(READ_LAT - 1);

    logic [15:0]           mem_r [0:DEPTH-1];

    state_t                state_r;
    logic [3:0]            lat_cnt_r;
    logic                  drive_r;
    logic [MEM_ADDR_W-1:0] lat_idx_r;
    logic                  lat_ub_n_r;
    logic                  lat_lb_n_r;
    logic [15:0]           rd_count_r;
    logic [15:0]           wr_count_r;
    logic                  busy_r;
    logic                  proto_err_r;
    logic                  chk_done_r;

    logic [MEM_ADDR_W-1:0] idx_s;
    logic                  is_write_s;
    logic                  is_read_s;
    logic                  proto_viol_s;
    logic                  same_addr_s;
    logic                  start_rd_s;
    logic [15:0]           rd_word_s;
    logic                  drv_hi_s;
    logic                  drv_lo_s;

    assign idx_s        = SRAM_ADDR[MEM_ADDR_W-1:0];
    assign is_write_s   = ~SRAM_CE_N & ~SRAM_WE_N;
    assign is_read_s    = ~SRAM_CE_N & SRAM_WE_N & ~SRAM_OE_N;
    assign proto_viol_s = ~SRAM_CE_N & ~SRAM_WE_N & ~SRAM_OE_N;
    assign same_addr_s  = (idx_s == lat_idx_r);

    // A read edge starts a fresh access unless it continues the one in WAIT/DRIVE.
    assign start_rd_s = is_read_s &
                        (((state_r != ST_WAIT) && (state_r != ST_DRIVE)) | ~same_addr_s);

    // Upper address bits alias away; the latched lanes are kept for visibility only.
    generate
        if (MEM_ADDR_W < 18) begin : g_alias
            logic unused_addr_s;
            assign unused_addr_s = ^SRAM_ADDR[17:MEM_ADDR_W];
        end
    endgenerate
    logic unused_lanes_s;
    assign unused_lanes_s = lat_ub_n_r ^ lat_lb_n_r;

    // Storage: byte-lane writes, never cleared by reset.
    always_ff @(posedge clk) begin
        if (rst && is_write_s) begin
            if (!SRAM_UB_N) begin
                mem_r[idx_s][15:8] <= SRAM_DQ[15:8];
            end
            if (!SRAM_LB_N) begin
                mem_r[idx_s][7:0] <= SRAM_DQ[7:0];
            end
        end
    end

    // Access FSM, counters and sticky protocol flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            lat_cnt_r   <= 4'd0;
            drive_r     <= 1'b0;
            lat_idx_r   <= '0;
            lat_ub_n_r  <= 1'b1;
            lat_lb_n_r  <= 1'b1;
            rd_count_r  <= 16'd0;
            wr_count_r  <= 16'd0;
            busy_r      <= 1'b0;
            proto_err_r <= 1'b0;
            chk_done_r  <= 1'b0;
        end else begin
            chk_done_r <= 1'b1;
            if ((!chk_done_r && !LAT_OK) || proto_viol_s) begin
                proto_err_r <= 1'b1;
            end

            if (is_write_s) begin
                wr_count_r <= wr_count_r + 16'd1;
                state_r    <= ST_IDLE;
                lat_cnt_r  <= 4'd0;
                drive_r    <= 1'b0;
                busy_r     <= 1'b0;
            end else if (start_rd_s) begin
                lat_idx_r  <= idx_s;
                lat_ub_n_r <= SRAM_UB_N;
                lat_lb_n_r <= SRAM_LB_N;
                rd_count_r <= rd_count_r + 16'd1;
                if (LAT_ONE) begin
                    state_r   <= ST_DRIVE;
                    lat_cnt_r <= 4'd0;
                    drive_r   <= 1'b1;
                    busy_r    <= 1'b0;
                end else begin
                    state_r   <= ST_WAIT;
                    lat_cnt_r <= LAT_RELOAD;
                    drive_r   <= 1'b0;
                    busy_r    <= 1'b1;
                end
            end else if (is_read_s) begin
                case (state_r)
                    ST_WAIT: begin
                        // A zero count only arises from an illegal latency; treat it as done.
                        if (lat_cnt_r <= 4'd1) begin
                            state_r   <= ST_DRIVE;
                            lat_cnt_r <= 4'd0;
                            drive_r   <= 1'b1;
                            busy_r    <= 1'b0;
                        end else begin
                            lat_cnt_r <= lat_cnt_r - 4'd1;
                        end
                    end
                    ST_DRIVE: begin
                        lat_ub_n_r <= SRAM_UB_N;
                        lat_lb_n_r <= SRAM_LB_N;
                        drive_r    <= 1'b1;
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        lat_cnt_r <= 4'd0;
                        drive_r   <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                endcase
            end else begin
                state_r   <= ST_IDLE;
                lat_cnt_r <= 4'd0;
                drive_r   <= 1'b0;
                busy_r    <= 1'b0;
            end
        end
    end

    // Lane gating is combinational so the bus is released the same cycle OE/CE/WE rises.
    assign rd_word_s = mem_r[lat_idx_r];
    assign drv_hi_s  = drive_r & ~SRAM_CE_N & ~SRAM_OE_N & SRAM_WE_N & ~SRAM_UB_N;
    assign drv_lo_s  = drive_r & ~SRAM_CE_N & ~SRAM_OE_N & SRAM_WE_N & ~SRAM_LB_N;

    assign SRAM_DQ[15:8] = drv_hi_s ? rd_word_s[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = drv_lo_s ? rd_word_s[7:0]  : 8'hzz;

    assign rd_count  = rd_count_r;
    assign wr_count  = wr_count_r;
    assign busy      = busy_r;
    assign proto_err = proto_err_r;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: vector table on a READ_LAT=2 instance plus
// hand sequences for latency restart, turnaround, protocol errors and reset.
module tb_sram_responder;

    localparam int K_R = 0;
    localparam int K_W = 1;
    localparam int K_N = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] addr;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;
    logic        drv_en;
    logic [15:0] drv_d;

    wire  [15:0] dq_a, dq_b, dq_c;
    logic [15:0] rd_a, wr_a, rd_b, wr_b, rd_c, wr_c;
    logic        busy_a, pe_a, busy_b, pe_b, busy_c, pe_c;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Bench-side data driver; released lines float high through the pullups.
    assign dq_a = drv_en ? drv_d : 16'hzzzz;
    assign dq_b = drv_en ? drv_d : 16'hzzzz;
    assign dq_c = drv_en ? drv_d : 16'hzzzz;
    for (genvar gi = 0; gi < 16; gi++) begin : g_pull
        pullup (dq_a[gi]);
        pullup (dq_b[gi]);
        pullup (dq_c[gi]);
    end

    sram_responder #(.MEM_ADDR_W(16), .READ_LAT(2)) u_dut (
        .clk(clk), .rst(rst), .SRAM_DQ(dq_a), .SRAM_ADDR(addr),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
        .rd_count(rd_a), .wr_count(wr_a), .busy(busy_a), .proto_err(pe_a));

    sram_responder #(.MEM_ADDR_W(16), .READ_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .SRAM_DQ(dq_b), .SRAM_ADDR(addr),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
        .rd_count(rd_b), .wr_count(wr_b), .busy(busy_b), .proto_err(pe_b));

    sram_responder #(.MEM_ADDR_W(4), .READ_LAT(0)) u_bad (
        .clk(clk), .rst(rst), .SRAM_DQ(dq_c), .SRAM_ADDR(addr),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
        .rd_count(rd_c), .wr_count(wr_c), .busy(busy_c), .proto_err(pe_c));

    typedef struct {
        logic        ce_n, we_n, oe_n, ub_n, lb_n;
        logic [17:0] addr;
        logic        drv_en;
        logic [15:0] drv_d;
        logic [15:0] exp_dq;
        logic        exp_busy;
        logic [15:0] exp_rd;
        logic [15:0] exp_wr;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input int k, input logic [17:0] a, input logic [15:0] d,
                         input logic ub, input logic lb);
        @(negedge clk);
        ce_n   = (k == K_N);
        we_n   = (k != K_W);
        oe_n   = (k != K_R);
        ub_n   = ub;
        lb_n   = lb;
        addr   = a;
        drv_en = (k == K_W);
        drv_d  = d;
    endtask

    task automatic step(input int k, input logic [17:0] a, input logic [15:0] d,
                        input logic ub, input logic lb);
        drive(k, a, d, ub, lb);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int k, input logic [17:0] a, input logic [15:0] d,
                       input logic ub, input logic lb, input logic [15:0] edq,
                       input logic eb, input logic [15:0] er, input logic [15:0] ew);
        vec_t v;
        v.ce_n = (k == K_N); v.we_n = (k != K_W); v.oe_n = (k != K_R);
        v.ub_n = ub; v.lb_n = lb; v.addr = a;
        v.drv_en = (k == K_W); v.drv_d = d;
        v.exp_dq = edq; v.exp_busy = eb; v.exp_rd = er; v.exp_wr = ew;
        vt.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0;
        addr = 18'd0; drv_en = 1'b0; drv_d = 16'd0;

        // Main table, READ_LAT=2: op, addr, wdata, ub_n, lb_n, dq, busy, rd_count, wr_count
        add(K_R, 18'h00005, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16'd1, 16'd0);
        add(K_R, 18'h00005, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b0, 16'd1, 16'd0);
        add(K_N, 18'h00005, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 16'd1, 16'd0);
        add(K_W, 18'h00010, 16'hA5C3, 1'b0, 1'b0, 16'hA5C3, 1'b0, 16'd1, 16'd1);
        add(K_R, 18'h00010, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16'd2, 16'd1);
        add(K_R, 18'h00010, 16'h0000, 1'b0, 1'b0, 16'hA5C3, 1'b0, 16'd2, 16'd1);
        add(K_R, 18'h00010, 16'h0000, 1'b0, 1'b0, 16'hA5C3, 1'b0, 16'd2, 16'd1);
        add(K_N, 18'h00010, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 16'd2, 16'd1);
        add(K_W, 18'h00003, 16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0, 16'd2, 16'd2);
        add(K_W, 18'h00003, 16'hFF00, 1'b0, 1'b1, 16'hFF00, 1'b0, 16'd2, 16'd3);
        add(K_R, 18'h00003, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16'd3, 16'd3);
        add(K_R, 18'h00003, 16'h0000, 1'b0, 1'b0, 16'hFF34, 1'b0, 16'd3, 16'd3);
        add(K_R, 18'h00003, 16'h0000, 1'b1, 1'b0, 16'hFF34, 1'b0, 16'd3, 16'd3);
        add(K_W, 18'h00004, 16'h5678, 1'b0, 1'b0, 16'h5678, 1'b0, 16'd3, 16'd4);
        add(K_R, 18'h00004, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16'd4, 16'd4);
        add(K_R, 18'h00004, 16'h0000, 1'b1, 1'b0, 16'hFF78, 1'b0, 16'd4, 16'd4);
        add(K_R, 18'h00004, 16'h0000, 1'b0, 1'b1, 16'h56FF, 1'b0, 16'd4, 16'd4);
        add(K_N, 18'h00004, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 16'd4, 16'd4);
        add(K_W, 18'h10007, 16'h0F0F, 1'b0, 1'b0, 16'h0F0F, 1'b0, 16'd4, 16'd5);
        add(K_R, 18'h00007, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16'd5, 16'd5);
        add(K_R, 18'h00007, 16'h0000, 1'b0, 1'b0, 16'h0F0F, 1'b0, 16'd5, 16'd5);
        add(K_R, 18'h10007, 16'h0000, 1'b0, 1'b0, 16'h0F0F, 1'b0, 16'd5, 16'd5);
        add(K_R, 18'h00010, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16'd6, 16'd5);
        add(K_R, 18'h00010, 16'h0000, 1'b0, 1'b0, 16'hA5C3, 1'b0, 16'd6, 16'd5);
        add(K_W, 18'h00010, 16'h1357, 1'b0, 1'b0, 16'h1357, 1'b0, 16'd6, 16'd6);
        add(K_R, 18'h00010, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16'd7, 16'd6);
        add(K_R, 18'h00010, 16'h0000, 1'b0, 1'b0, 16'h1357, 1'b0, 16'd7, 16'd6);
        add(K_R, 18'h00005, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16'd8, 16'd6);
        add(K_W, 18'h00005, 16'h2468, 1'b0, 1'b0, 16'h2468, 1'b0, 16'd8, 16'd7);
        add(K_R, 18'h00005, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16'd9, 16'd7);
        add(K_R, 18'h00005, 16'h0000, 1'b0, 1'b0, 16'h2468, 1'b0, 16'd9, 16'd7);
        add(K_N, 18'h00005, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 16'd9, 16'd7);

        // Pre-write mem[5], then reset with a read presented: bus must float.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(K_W, 18'h00005, 16'hBEEF, 1'b0, 1'b0);
        check("wr after first write", wr_a, 16'd1);
        check("bad latency flagged", {15'd0, pe_c}, 16'd1);
        check("no early proto_err", {15'd0, pe_a}, 16'd0);
        drive(K_R, 18'h00005, 16'h0000, 1'b0, 1'b0);
        #1 rst = 1'b0;
        #1;
        check("reset dq released", dq_a, 16'hFFFF);
        check("reset rd_count", rd_a, 16'd0);
        check("reset wr_count", wr_a, 16'd0);
        check("reset busy", {15'd0, busy_a}, 16'd0);
        check("reset proto_err", {15'd0, pe_a}, 16'd0);
        check("reset clears bad flag", {15'd0, pe_c}, 16'd0);
        @(negedge clk);
        ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
        rst = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            ce_n = vt[i].ce_n; we_n = vt[i].we_n; oe_n = vt[i].oe_n;
            ub_n = vt[i].ub_n; lb_n = vt[i].lb_n; addr = vt[i].addr;
            drv_en = vt[i].drv_en; drv_d = vt[i].drv_d;
            @(posedge clk);
            #1;
            check($sformatf("v%0d dq", i), dq_a, vt[i].exp_dq);
            check($sformatf("v%0d busy", i), {15'd0, busy_a}, {15'd0, vt[i].exp_busy});
            check($sformatf("v%0d rd_count", i), rd_a, vt[i].exp_rd);
            check($sformatf("v%0d wr_count", i), wr_a, vt[i].exp_wr);
        end
        check("no proto_err in table", {15'd0, pe_a}, 16'd0);

        // READ_LAT=3: address change mid-WAIT restarts the latency.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(K_W, 18'h00014, 16'h0A14, 1'b0, 1'b0);
        step(K_W, 18'h00015, 16'h0B15, 1'b0, 1'b0);
        check("l3 wr_count", wr_b, 16'd2);
        step(K_R, 18'h00014, 16'h0000, 1'b0, 1'b0);
        check("l3 first busy", {15'd0, busy_b}, 16'd1);
        check("l3 first rd", rd_b, 16'd1);
        step(K_R, 18'h00015, 16'h0000, 1'b0, 1'b0);
        check("l3 change busy", {15'd0, busy_b}, 16'd1);
        check("l3 change rd", rd_b, 16'd2);
        check("l3 change dq", dq_b, 16'hFFFF);
        step(K_R, 18'h00015, 16'h0000, 1'b0, 1'b0);
        check("l3 wait2 busy", {15'd0, busy_b}, 16'd1);
        check("l3 wait2 dq", dq_b, 16'hFFFF);
        step(K_R, 18'h00015, 16'h0000, 1'b0, 1'b0);
        check("l3 data busy", {15'd0, busy_b}, 16'd0);
        check("l3 data dq", dq_b, 16'h0B15);
        check("l3 data rd", rd_b, 16'd2);
        step(K_R, 18'h00014, 16'h0000, 1'b0, 1'b0);
        check("l3 reread busy", {15'd0, busy_b}, 16'd1);
        check("l3 reread rd", rd_b, 16'd3);
        step(K_N, 18'h00014, 16'h0000, 1'b0, 1'b0);
        check("l3 abort busy", {15'd0, busy_b}, 16'd0);
        drive(K_R, 18'h00014, 16'h0000, 1'b0, 1'b0);
        #1;
        check("l3 abort no drive", dq_b, 16'hFFFF);
        @(posedge clk);
        #1;
        check("l3 restart rd", rd_b, 16'd4);
        check("l3 restart busy", {15'd0, busy_b}, 16'd1);

        // Protocol violation: write still lands, flag sticks until reset.
        step(K_N, 18'h00000, 16'h0000, 1'b0, 1'b0);
        check("proto clear before", {15'd0, pe_a}, 16'd0);
        drive(K_W, 18'h0001E, 16'h7E81, 1'b0, 1'b0);
        oe_n = 1'b0;
        @(posedge clk);
        #1;
        check("proto set", {15'd0, pe_a}, 16'd1);
        check("proto write counted", wr_a, 16'd3);
        step(K_N, 18'h0001E, 16'h0000, 1'b0, 1'b0);
        check("proto sticky", {15'd0, pe_a}, 16'd1);
        step(K_R, 18'h0001E, 16'h0000, 1'b0, 1'b0);
        step(K_R, 18'h0001E, 16'h0000, 1'b0, 1'b0);
        check("proto write landed", dq_a, 16'h7E81);
        @(negedge clk);
        oe_n = 1'b1;
        #1;
        check("oe rise releases bus", dq_a, 16'hFFFF);
        rst = 1'b0;
        #1;
        check("proto cleared by reset", {15'd0, pe_a}, 16'd0);
        check("rd cleared by reset", rd_a, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable responder model of the 256Kx16 asynchronous SRAM on the far side of the SRAM pin bus driven by the memory-stage SRAM controller.
- Owns the word storage, decodes CE/OE/WE/UB/LB, and drives or releases the bidirectional data bus.
- Emulates a configurable read access latency in clock cycles.
- Used as the on-chip SRAM stand-in for simulation and FPGA builds without the external chip, and as the bus-side checker for controller verification.

Parameters:
- MEM_ADDR_W, 16, implemented word-address bits; storage depth = 2^MEM_ADDR_W x 16 bits. SRAM_ADDR bits above this width are ignored, so addresses alias modulo the depth.
- READ_LAT, 2, clock cycles from the read-sampling edge to valid data on SRAM_DQ; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-low
- SRAM_DQ  inout  16  data bus; responder drives only during a read data phase
- SRAM_ADDR  input  18  word address
- SRAM_UB_N  input  1  high-byte lane enable, active-low
- SRAM_LB_N  input  1  low-byte lane enable, active-low
- SRAM_WE_N  input  1  write enable, active-low
- SRAM_CE_N  input  1  chip enable, active-low
- SRAM_OE_N  input  1  output enable, active-low
- rd_count  output  16  accepted reads, wraps at 65535->0
- wr_count  output  16  write edges performed, wraps
- busy  output  1  high while a read is in its latency wait
- proto_err  output  1  sticky protocol-violation flag

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; latency counter 0; drive register 0, so SRAM_DQ goes Z immediately; rd_count=0, wr_count=0, busy=0, proto_err=0. Storage contents are not cleared. A read in flight is abandoned.
- Bus decode, sampled at each rising clk edge. Let idx = SRAM_ADDR[MEM_ADDR_W-1:0].
  - WRITE: CE_N=0 and WE_N=0. WE dominates OE.
  - READ: CE_N=0, WE_N=1 and OE_N=0.
  - NONE: any other combination.
- WRITE, performed in any state:
  - At the edge, mem[idx][15:8] <= DQ[15:8] if UB_N=0; mem[idx][7:0] <= DQ[7:0] if LB_N=0.
  - wr_count increments once per edge, including when both lanes are masked.
  - The state returns to IDLE and any pending read is aborted. A write held for N edges counts N.
  - A read of the same address issued on the next cycle returns the new data.
- IDLE, on a READ edge:
  - Latch idx, UB_N and LB_N; rd_count increments.
  - If READ_LAT=1, go to DRIVE. Otherwise go to WAIT with counter = READ_LAT-1 and busy=1.
- WAIT:
  - Each READ edge with an unchanged address decrements the counter; on reaching 0, go to DRIVE and set busy=0.
  - A READ edge with a changed address re-latches, restarts the latency and increments rd_count.
  - A NONE edge returns to IDLE (read aborted, no data driven).
- DRIVE:
  - Drive register is 1. The lane enables latched at read-sample time are refreshed from the live UB_N/LB_N each edge.
  - A READ edge with the same address holds DRIVE.
  - A READ edge with a new address behaves as a new read from IDLE (re-latch, count, restart latency; drive register cleared if READ_LAT>1).
  - A NONE edge returns to IDLE.
- Data output, combinational:
  - DQ[15:8] = mem[latched idx][15:8] when drive_reg & ~CE_N & ~OE_N & WE_N & ~UB_N; else Z. DQ[7:0] follows the same rule with LB_N.
  - Because the gating is combinational, the bus is released in the same cycle that OE_N, CE_N or WE_N rises, so there is never contention with a controller write.
  - Data reflects the current storage contents at the latched index.
- proto_err is set and held until reset on any edge where:
  - CE_N=0, WE_N=0 and OE_N=0 (the write is still performed); or
  - READ_LAT is outside 1..15 (checked at the first edge after reset).
- Simultaneous events: write and read cannot coincide (decode priority is WRITE > READ > NONE). Reset overrides everything.

Test Plan:
- Reset with DQ pulled from outside -> DQ=Z; counts=0; busy=0; proto_err=0. A pre-written mem[5]=16'hBEEF survives reset.
- READ_LAT=2: write 16'hA5C3 to addr 18'h00010, then hold READ at 10 -> busy=1 for 1 cycle; DQ=16'hA5C3 from the 2nd cycle after sampling; rd_count=1, wr_count=1.
- Byte write: mem[3]=16'h1234, then write 16'hFF00 with LB_N=1 -> read returns 16'hFF34. Read with UB_N=1 -> DQ[15:8]=Z, DQ[7:0]=8'h34.
- Aliasing with MEM_ADDR_W=16: write 16'h0F0F at 18'h10007, read 18'h00007 -> 16'h0F0F.
- Address change mid-WAIT (READ_LAT=3): read 20, then read 21 after 1 cycle -> DQ shows mem[21] 3 cycles after the change; rd_count=2. A NONE edge in WAIT -> IDLE, DQ never driven.
- Read-then-write turnaround: raise OE_N and drop WE_N in the same cycle -> DQ released that cycle, write lands; CE_N=WE_N=OE_N=0 -> proto_err=1 and stays 1 until rst=0.
